// File: rtl/pwm_duty_display.sv
// pwm_duty_display: measures comparator PWM duty in percent (0-99) once per window
// and shows it on a two-digit multiplexed seven-segment display.
module pwm_duty_display #(
    parameter int PERIOD_CYCLES = 200000,
    parameter int UNIT_CYCLES   = 2000,
    parameter int DISP_CYCLES   = 1000000,
    parameter int MUX_CYCLES    = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       comp,
    output logic [6:0] valid_count,
    output logic [6:0] showed_count,
    output logic [6:0] seg,
    output logic [1:0] digit_sel
);
    localparam int WW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
    localparam int SW = UNIT_CYCLES > 1 ? $clog2(UNIT_CYCLES) : 1;
    localparam int DW = DISP_CYCLES > 1 ? $clog2(DISP_CYCLES) : 1;
    localparam int MW = MUX_CYCLES > 1 ? $clog2(MUX_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [WW-1:0] win_q, win_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [6:0]    duty_q, duty_d, duty_inc;
    logic [6:0]    valid_q, valid_d;
    logic [DW-1:0] disp_q, disp_d;
    logic [6:0]    showed_q, showed_d;
    logic [MW-1:0] mux_q, mux_d;
    logic [1:0]    sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic          comp_s, unit_hit, win_end, disp_end, mux_end;
    logic [3:0]    tens, units;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        comp_s   = sync_q[1];
        unit_hit = comp_s && sub_q == SW'(UNIT_CYCLES - 1);
        duty_inc = (unit_hit && duty_q != 7'd127) ? duty_q + 7'd1 : duty_q;
        win_end  = win_q == WW'(PERIOD_CYCLES - 1);
        win_d    = win_end ? '0 : win_q + WW'(1);
        sub_d    = (win_end || unit_hit) ? '0 : sub_q + SW'(comp_s);
        duty_d   = win_end ? '0 : duty_inc;
        // the closing clock's own sample is already folded into duty_inc
        valid_d  = win_end ? (duty_inc > 7'd99 ? 7'd99 : duty_inc) : valid_q;
        disp_end = disp_q == DW'(DISP_CYCLES - 1);
        disp_d   = disp_end ? '0 : disp_q + DW'(1);
        showed_d = disp_end ? valid_q : showed_q;
        tens     = 4'(showed_q / 7'd10);
        units    = 4'(showed_q % 7'd10);
        mux_end  = mux_q == MW'(MUX_CYCLES - 1);
        mux_d    = mux_end ? '0 : mux_q + MW'(1);
        sel_d    = mux_end ? ~sel_q : sel_q;
        // sel_q[0] set means the tens digit is the one about to be selected
        seg_d    = mux_end ? (sel_q[0] ? (tens == 4'd0 ? 7'h00 : enc(tens)) : enc(units)) : seg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            win_q    <= '0;
            sub_q    <= '0;
            duty_q   <= '0;
            valid_q  <= '0;
            disp_q   <= '0;
            showed_q <= '0;
            mux_q    <= '0;
            sel_q    <= 2'b01;
            seg_q    <= 7'h3F;
        end else begin
            sync_q   <= {sync_q[0], comp};
            win_q    <= win_d;
            sub_q    <= sub_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            disp_q   <= disp_d;
            showed_q <= showed_d;
            mux_q    <= mux_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
        end
    end

    assign valid_count  = valid_q;
    assign showed_count = showed_q;
    assign seg          = seg_q;
    assign digit_sel    = sel_q;
endmodule

// File: tb/tb_pwm_duty_display.sv
// tb_pwm_duty_display: randomized PWM stimulus checked against a per-window
// high-time reference model and fixed expectations for each scenario.
module tb_pwm_duty_display;
    localparam int P = 1000;
    localparam int U = 10;
    localparam int D = 2000;
    localparam int M = 50;
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       comp = 1'b0;
    logic [6:0] valid_count, showed_count, seg;
    logic [1:0] digit_sel;
    int         n_checks = 0;
    int         n_errs = 0;

    pwm_duty_display #(
        .PERIOD_CYCLES(P),
        .UNIT_CYCLES  (U),
        .DISP_CYCLES  (D),
        .MUX_CYCLES   (M)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .comp        (comp),
        .valid_count (valid_count),
        .showed_count(showed_count),
        .seg         (seg),
        .digit_sel   (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int shown(input int sel, input int v);
        int tens = v / 10;
        if (sel == 2) return tens == 0 ? 0 : int'(SEG[tens]);
        return int'(SEG[v % 10]);
    endfunction

    // reference: count synchronized high clocks per window, divide at window end
    int   m_t = 0, m_high = 0, m_valid = 0, m_showed = 0, m_seg = 'h3F, m_sel = 1;
    logic m_c1 = 1'b0, m_c2 = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_high = 0; m_valid = 0; m_showed = 0;
            m_seg = 'h3F; m_sel = 1; m_c1 = 1'b0; m_c2 = 1'b0;
        end else begin
            m_t++;
            m_high += int'(m_c2);
            m_c2 = m_c1;
            m_c1 = comp;
            if (m_t % M == 0) begin
                m_sel = 3 - m_sel;
                m_seg = shown(m_sel, m_showed);
            end
            if (m_t % D == 0) m_showed = m_valid;
            if (m_t % P == 0) begin
                m_valid = (m_high / U > 99) ? 99 : m_high / U;
                m_high = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid_count", int'(valid_count), m_valid);
            check("showed_count", int'(showed_count), m_showed);
            check("seg", int'(seg), m_seg);
            check("digit_sel", int'(digit_sel), m_sel);
        end
    end

    // PWM source: high time h per period, optionally split around the period edge
    int ph = 0, h = 0, h_next = 0;
    bit sp = 1'b0, sp_next = 1'b0;
    always @(posedge clk) begin
        #1;
        ph = (ph + 1) % P;
        if (ph == 0) begin
            h = h_next;
            sp = sp_next;
        end
        comp = sp ? (ph < h / 2 || ph >= P - (h - h / 2)) : (ph < h);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_sel(input logic [1:0] s);
        int n = 0;
        while (digit_sel !== s && n < 4 * M) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("digit_sel_wait", int'(digit_sel), int'(s));
    endtask

    task automatic set_pwm(input int hi, input bit split);
        ph = int'($urandom_range(0, P - 1));
        h = hi;
        sp = split;
        h_next = hi;
        sp_next = split;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, int'(valid_count), 0);
        check({tag, "_showed"}, int'(showed_count), 0);
        check({tag, "_seg"}, int'(seg), 'h3F);
        check({tag, "_sel"}, int'(digit_sel), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        cycles(3);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        cycles(1);
        check_reset_values("after_release");
        cycles(P - 1);
        check("first_window", int'(valid_count), 0);
        wait_sel(2'b10);
        check("tens_blank", int'(seg), 0);

        set_pwm(370, 1'b0);
        cycles(3 * P);
        check("contig_37", int'(valid_count), 37);
        cycles(D);
        check("showed_37", int'(showed_count), 37);
        wait_sel(2'b10);
        check("tens_3", int'(seg), 'h4F);
        wait_sel(2'b01);
        check("units_7", int'(seg), 'h07);

        set_pwm(370, 1'b1);
        cycles(3 * P);
        check("split_37", int'(valid_count), 37);
        set_pwm(375, 1'b0);
        cycles(3 * P);
        check("floor_37", int'(valid_count), 37);

        set_pwm(P, 1'b0);
        cycles(3 * P);
        check("sat_99", int'(valid_count), 99);
        cycles(D);
        check("sat_showed", int'(showed_count), 99);
        wait_sel(2'b10);
        check("sat_tens", int'(seg), 'h6F);
        wait_sel(2'b01);
        check("sat_units", int'(seg), 'h6F);
        set_pwm(0, 1'b0);
        cycles(2 * P + 10);
        check("low_0", int'(valid_count), 0);

        repeat (4) begin
            int hi = int'($urandom_range(0, P));
            set_pwm(hi, 1'($urandom_range(0, 1)));
            cycles(3 * P);
            check("random_duty", int'(valid_count), hi / U > 99 ? 99 : hi / U);
        end

        set_pwm(0, 1'b0);
        for (int i = 0; i < 100; i += 11) begin
            h_next = i * U;
            cycles(P);
            check("ramp_cap", int'(valid_count > 7'd99), 0);
        end
        cycles(2 * P);
        check("ramp_top", int'(valid_count), 99);

        set_pwm(P, 1'b0);
        cycles(3 * P);
        check("pre_reset_99", int'(valid_count), 99);
        begin
            int n = 0;
            while (m_t % P != 500 && n < 2 * P) begin
                @(posedge clk);
                #2;
                n++;
            end
            check("reach_500", m_t % P, 500);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (P - 1) @(posedge clk);
        #2;
        check("no_early_update", int'(valid_count), 0);
        @(posedge clk);
        #2;
        check("update_after_reset", int'(valid_count), 99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/pwm_duty_display.md
# pwm_duty_display

Measures the duty cycle of the joystick comparator's PWM output and drives a two-digit multiplexed seven-segment display with the result in percent (0–99). It sits between the analog comparator front end and the display pins. A measurement stage produces `valid_count` once per PWM period. A display stage samples that value at a slower refresh rate and shows it on the display.

## Interface
- `PERIOD_CYCLES`, default 200000: clocks per measurement window. This is the PWM period, 20 ms at 10 MHz.
- `UNIT_CYCLES`, default 2000: high-time clocks per 1 % step. Must be less than or equal to `PERIOD_CYCLES`.
- `DISP_CYCLES`, default 1000000: clocks between display value updates (100 ms).
- `MUX_CYCLES`, default 10000: clocks per digit in the multiplexed display (1 ms).

Ports:
- `clk`, input, 1 bit: single system clock. All state is on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `comp`, input, 1 bit: comparator PWM output. Asynchronous to `clk`.
- `valid_count`, output, 7 bits: last measured duty in percent, 0–99. Registered.
- `showed_count`, output, 7 bits: value currently displayed, 0–99. Registered.
- `seg`, output, 7 bits: segment pattern, bit order {g,f,e,d,c,b,a}, active-high. Registered.
- `digit_sel`, output, 2 bits: one-hot digit enable, active-high. Bit 0 selects units, bit 1 selects tens. Registered.

## Operation
- **Synchronizer:** `comp` passes through a 2-flop synchronizer to produce `comp_s`.
- **Window counter:** counts 0 to `PERIOD_CYCLES`−1 and wraps. It free-runs from reset and is not aligned to PWM edges.
- **High-time accumulation:** each clock with `comp_s`=1 increments a sub-counter.
  - When the sub-counter reaches `UNIT_CYCLES`−1 on a high clock, it returns to 0 and the duty accumulator increments.
  - The duty accumulator saturates at 127.
  - The result is floor(high_clocks / `UNIT_CYCLES`).
- **End of window:** on the clock where the window counter equals `PERIOD_CYCLES`−1, that clock's sample is included. Then:
  - `valid_count` loads min(duty, 99) on the same edge.
  - The sub-counter and duty accumulator clear.
- **Phase independence:** because the window equals the PWM period, a stationary PWM measures the same regardless of phase. A pulse split across the window boundary (high t/2, low, high t/2) gives the same result as a contiguous pulse.
- **Display refresh:** a refresh counter ticks every `DISP_CYCLES` clocks. On each tick, `showed_count` loads `valid_count`.
- **Digit split:** `showed_count` is split into tens = `showed_count`/10 and units = `showed_count`%10.
- **Digit multiplexing:** a mux counter toggles the active digit every `MUX_CYCLES` clocks.
  - `digit_sel` alternates 01 → 10 → 01.
  - `seg` shows the digit for the newly selected position, registered together with `digit_sel`.
- **Segment encoding:**
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66.
  - 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F.
- **Leading zero blanking:** when tens = 0, the tens position shows 7'h00. The units digit always displays, so 0 shows as "0".

## Timing
- **Reset values:**
  - `valid_count`=0, `showed_count`=0.
  - `digit_sel`=2'b01, `seg`=7'h3F.
  - All counters, the accumulator and the synchronizer clear to 0.
- **Reset mid-window:** all state clears immediately (asynchronous). A fresh window starts on the first clock after release.
- **Input latency:** 2 clocks from `comp` to `comp_s`.
  - The first `PERIOD_CYCLES` window after reset therefore undercounts by up to 2 clocks of high time.
- **`valid_count` timing:** updates once per window, `PERIOD_CYCLES` clocks after reset release and every `PERIOD_CYCLES` thereafter. It holds between updates.
- **`showed_count` timing:** updates every `DISP_CYCLES` clocks, first at `DISP_CYCLES` after reset. It holds between updates.
- **Digit timing:** the first digit toggle happens `MUX_CYCLES` clocks after reset. Each digit is active for exactly `MUX_CYCLES` clocks.
- **Simultaneous events:**
  - If a window end and a display tick fall on the same clock, `showed_count` takes the old `valid_count`.
  - If a display tick and a mux toggle fall on the same clock, `seg` decodes the old `showed_count`.
- **Saturation:** a constant-high input gives 100 internally, which is clamped to 99. Accumulator overflow is impossible with the default parameters.

## Test plan
Bench parameters for all scenarios: `PERIOD_CYCLES`=1000, `UNIT_CYCLES`=10, `DISP_CYCLES`=2000, `MUX_CYCLES`=50.

- **Reset state:** after reset release, `comp`=0 → `valid_count`=0, `showed_count`=0, `digit_sel`=01, `seg`=7'h3F. After the first window, `valid_count` is still 0. While `digit_sel`=10, `seg`=7'h00.
- **Contiguous pulse:** PWM high 370 / low 630 clocks, repeated → `valid_count`=37 from the second window on. After the next display tick, `showed_count`=37; tens `seg`=7'h4F, units `seg`=7'h07.
- **Split pulse and floor:** split pulse (high 185, low 630, high 185) at arbitrary phase → 37. A 375-high pulse → 37 (floor).
- **Saturation:** `comp` constant 1 → `valid_count`=99 (clamped), display shows 7'h6F/7'h6F. Then `comp` constant 0 → 0 within 2 windows.
- **Ramp:** high time i×10 for i = 0..99, each held one period → `valid_count` tracks i, lagging by at most one window. It never exceeds 99.
- **Mid-window reset:** assert `rst_n`=0 at window clock 500 → all outputs return to their reset values within the same clock. After release, the next update is 1000 clocks later.
